// File: rtl/dvi_rx_tmds_dec.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : dvi_rx_tmds_dec
// Purpose  : DVI receive TMDS lane decoder with control-token boundary lock
// Revision : 1.0
// ============================================================================
module dvi_rx_tmds_dec #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] tmds_i,
  output logic       bitslip_o,
  output logic       aligned_o,
  output logic       den_o,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o
);

  localparam int                RUN_W       = $clog2(CTRL_RUN + 1);
  localparam int                WAIT_W      = $clog2(SLIP_WAIT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(CTRL_RUN);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [15:0]       SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [15:0]       LOCK_LIMIT  = 16'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        s1_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [15:0]       gap_q, gap_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bitslip_q, bitslip_d;
  logic              den_q;
  logic [7:0]        data_q;
  logic [1:0]        ctrl_q;

  logic              w_is_tok;
  logic [1:0]        w_tok_ctrl;
  logic [7:0]        w_d;
  logic [6:0]        w_x;
  logic [7:0]        w_pix;

  always_comb begin
    w_is_tok   = 1'b1;
    w_tok_ctrl = 2'b00;
    case (s1_q)
      10'b1101010100: w_tok_ctrl = 2'b00;
      10'b0010101011: w_tok_ctrl = 2'b01;
      10'b0101010100: w_tok_ctrl = 2'b10;
      10'b1010101011: w_tok_ctrl = 2'b11;
      default:        w_is_tok   = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign w_d   = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
  assign w_x   = w_d[7:1] ^ w_d[6:0];
  assign w_pix = {(s1_q[8] ? w_x : ~w_x), w_d[0]};

  always_comb begin
    run_d     = w_is_tok ? ((run_q == RUN_MAX) ? run_q : run_q + 1'b1) : '0;
    gap_d     = w_is_tok ? 16'd0 : ((gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1);
    wait_d    = '0;
    bitslip_d = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (run_d == RUN_MAX) begin
          state_d = ST_LOCKED;
        end else if (!w_is_tok && (gap_q == SEARCH_LAST)) begin
          state_d   = ST_SLIP_WAIT;
          bitslip_d = 1'b1;
          run_d     = '0;
          gap_d     = 16'd0;
        end
      end
      ST_SLIP_WAIT: begin
        run_d  = '0;
        gap_d  = 16'd0;
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SEARCH;
          wait_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (gap_d == LOCK_LIMIT) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          gap_d   = 16'd0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_SEARCH;
      s1_q      <= 10'd0;
      run_q     <= '0;
      gap_q     <= 16'd0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
      den_q     <= 1'b0;
      data_q    <= 8'd0;
      ctrl_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      s1_q      <= tmds_i;
      run_q     <= run_d;
      gap_q     <= gap_d;
      wait_q    <= wait_d;
      bitslip_q <= bitslip_d;
      // Output stage is forced quiet until the boundary is locked.
      if (state_q == ST_LOCKED) begin
        if (w_is_tok) begin
          den_q  <= 1'b0;
          ctrl_q <= w_tok_ctrl;
        end else begin
          den_q  <= 1'b1;
          data_q <= w_pix;
        end
      end else begin
        den_q  <= 1'b0;
        data_q <= 8'd0;
        ctrl_q <= 2'b00;
      end
    end
  end

  assign bitslip_o = bitslip_q;
  assign aligned_o = (state_q == ST_LOCKED);
  assign den_o     = den_q;
  assign data_o    = data_q;
  assign ctrl_o    = ctrl_q;

endmodule
`default_nettype wire
